// File: rtl/stream_rr_arbiter.sv
// Purpose  : round-robin arbiter sharing one req/ack stream sink (typically a
//            FIFO write port) between N requester channels. The accepted word
//            is registered and tagged with its source channel id.
// Latency  : 1 cycle from acceptance to req_out; sustains 1 word/cycle.
// Backpressure: ack_in is only raised while the output register has space
//            (empty, or being drained this edge); a stalled sink freezes the
//            output word and all arbitration state.
//
// Ports
//   clk      in   1      clock
//   rstn     in   1      asynchronous active-low reset
//   d_in     in   N*dw   packed channel data, channel i at [i*dw +: dw]
//   req_in   in   N      per-channel request/valid
//   ack_in   out  N      per-channel accept, one-hot or zero
//   d_out    out  dw     registered output data
//   id_out   out  IW     source channel of d_out
//   req_out  out  1      output valid
//   ack_out  in   1      sink accept
//
// Build option
//   ARB_BURST_EN : when defined, a granted channel may keep the grant for up
//                  to MAXBURST consecutive beats (IDLE/LOCK state machine).
//                  When undefined the grant rotates after every transfer and
//                  the lock state, owner and beat counter do not exist.

module stream_rr_arbiter #(
  parameter int dw       = 8,
  parameter int N        = 4,
  parameter int MAXBURST = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N*dw-1:0]   d_in,
  input  logic [N-1:0]      req_in,
  output logic [N-1:0]      ack_in,
  output logic [dw-1:0]     d_out,
  output logic [$clog2(N)-1:0] id_out,
  output logic              req_out,
  input  logic              ack_out
);

  localparam int IW = $clog2(N);

  // --------------------------------------------------------------------------
  // Output stage and round-robin pointer
  // --------------------------------------------------------------------------
  logic [dw-1:0] r_dout;
  logic [IW-1:0] r_id;
  logic          r_vld;
  logic [IW-1:0] r_last;

  // Space in the output register: empty, or its word leaves on this edge.
  logic          w_space;

  // Round-robin search result.
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_start;
  logic          w_rr_found;
  logic [IW-1:0] w_rr_sel;

  // Final selection after any burst-lock override.
  logic          w_found;
  logic [IW-1:0] w_sel;
  logic          w_xfer;
  logic [dw-1:0] w_din_sel;

  assign w_space = ~r_vld | ack_out;

`ifdef ARB_BURST_EN
  // --------------------------------------------------------------------------
  // Burst-lock state
  // --------------------------------------------------------------------------
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;
  localparam int         CW     = $clog2(MAXBURST + 1);

  logic [0:0]    r_state;
  logic [IW-1:0] r_owner;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_own_hit;

  assign w_own_hit = (r_state == S_LOCK) && req_in[r_owner];
  assign w_cnt_inc = r_cnt + CW'(1);

  // In LOCK the owner was the last granted channel, so searching after the
  // owner is the same rotation point the plain round-robin would use.
  assign w_base  = (r_state == S_LOCK) ? r_owner : r_last;
  assign w_sel   = w_own_hit ? r_owner : w_rr_sel;
  assign w_found = w_own_hit | w_rr_found;
`else
  localparam int unused_maxburst = MAXBURST;

  assign w_base  = r_last;
  assign w_sel   = w_rr_sel;
  assign w_found = w_rr_found;
`endif

  // Search starts one past the base channel, wrapping N-1 -> 0.
  assign w_start = (w_base == IW'(N - 1)) ? '0 : (w_base + IW'(1));

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_rr_found && req_in[(int'(w_start) + k) % N]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = IW'((int'(w_start) + k) % N);
      end
    end
  end

  // A transfer needs a requester and room downstream; rstn gating keeps every
  // ack_in low for the whole reset, including the cycle reset is released in.
  assign w_xfer = w_found & w_space & rstn;

  always_comb begin
    ack_in = '0;
    if (w_xfer) begin
      ack_in[w_sel] = 1'b1;
    end
  end

  always_comb begin
    w_din_sel = d_in[int'(w_sel)*dw +: dw];
  end

  // --------------------------------------------------------------------------
  // Output register: loads on accept, clears when drained with nothing new.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout <= '0;
      r_id   <= '0;
      r_vld  <= 1'b0;
      r_last <= IW'(N - 1);
    end else if (w_xfer) begin
      r_dout <= w_din_sel;
      r_id   <= w_sel;
      r_vld  <= 1'b1;
      r_last <= w_sel;
    end else if (ack_out) begin
      r_vld  <= 1'b0;
    end
  end

`ifdef ARB_BURST_EN
  // --------------------------------------------------------------------------
  // Burst-lock state machine. Frozen entirely while the output is stalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
    end else if (w_space) begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer && (MAXBURST > 1)) begin
            r_state <= S_LOCK;
            r_owner <= w_sel;
            r_cnt   <= CW'(1);
          end
        end
        S_LOCK: begin
          if (w_own_hit) begin
            // Owner still requesting: it is granted (space is high here).
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CW'(MAXBURST)) begin
              r_state <= S_IDLE;
            end
          end else if (w_xfer) begin
            // Owner dropped; the next channel in rotation takes over the
            // lock in the same cycle with a fresh beat count.
            r_owner <= w_sel;
            r_cnt   <= CW'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
`endif

  assign d_out   = r_dout;
  assign id_out  = r_id;
  assign req_out = r_vld;

  // --------------------------------------------------------------------------
  // Protocol properties
  // --------------------------------------------------------------------------
  a_ack_onehot0: assert property (@(posedge clk) $onehot0(ack_in));

  a_no_ack_when_full: assert property (@(posedge clk)
    (r_vld && !ack_out) |-> (ack_in == '0));

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter (N=4, dw=8, MAXBURST=4). Channel i presents
// data {i, k} for its k-th word and advances k whenever it is acked.
// Expected words are queued by the stimulus; a monitor pops and compares
// each word as the sink consumes it.

module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N*DW-1:0] d_in;
  logic [N-1:0]    req_in;
  logic [N-1:0]    ack_in;
  logic [DW-1:0]   d_out;
  logic [1:0]      id_out;
  logic            req_out;
  logic            ack_out;

  stream_rr_arbiter #(.dw(DW), .N(N), .MAXBURST(MB)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .d_in    (d_in),
    .req_in  (req_in),
    .ack_in  (ack_in),
    .d_out   (d_out),
    .id_out  (id_out),
    .req_out (req_out),
    .ack_out (ack_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- source channels ----------------
  logic [3:0]   seq [N];
  logic [N-1:0] taken;

  always_comb begin
    for (int i = 0; i < N; i++) d_in[i*DW +: DW] = {4'(i), seq[i]};
  end

  always @(negedge clk) taken = req_in & ack_in;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (taken[i]) seq[i] = seq[i] + 4'd1;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic push(input int ch, input int k);
    q.push_back({2'(ch), 4'(ch), 4'(k)});
  endtask

  always @(negedge clk) begin
    if (rstn && req_out && ack_out) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got id=%0d dat=%h, expected no word", id_out, d_out);
      end else begin
        mon_e = q.pop_front();
        check("sb_word", 32'({id_out, d_out}), 32'({mon_e.id, mon_e.dat}));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_in  = '0;
    ack_out = 1'b0;
    rstn    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) seq[i] = 4'd0;
    @(negedge clk);
    rstn = 1'b1;
    cyc();
  endtask

  task automatic drain();
    req_in  = '0;
    ack_out = 1'b1;
    repeat (2) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    req_in  = '0;
    ack_out = 1'b0;
    rstn    = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 4'd0;

    // Reset behaviour, including reset while a word is held.
    do_reset();
    check("rst_req_out", 32'(req_out), 32'd0);
    check("rst_id_out", 32'(id_out), 32'd0);
    req_in  = 4'b1111;
    ack_out = 1'b0;
    @(negedge clk);
    check("rst_first_ack", 32'(ack_in), 32'b0001);
    cyc();
    check("first_req_out", 32'(req_out), 32'd1);
    check("first_id_out", 32'(id_out), 32'd0);
    @(negedge clk);
    check("full_ack_zero", 32'(ack_in), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_req_out", 32'(req_out), 32'd0);
    check("midrst_ack_in", 32'(ack_in), 32'd0);
    check("midrst_d_out", 32'(d_out), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel_ack_in", 32'(ack_in), 32'b0001);
    cyc();
    check("rel_id_out", 32'(id_out), 32'd0);
    check("rel_d_out", 32'(d_out), 32'h01);
    do_reset();

    // All channels requesting, sink always ready.
`ifdef ARB_BURST_EN
    for (int c = 0; c < 2; c++) for (int k = 0; k < 4; k++) push(c, k);
`else
    for (int k = 0; k < 2; k++) for (int c = 0; c < 4; c++) push(c, k);
`endif
    req_in  = 4'b1111;
    ack_out = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      check("stream_req_out", 32'(req_out), 32'd1);
    end
    drain();
    do_reset();

    // Backpressure: 3 stalled cycles in the middle of a stream.
`ifdef ARB_BURST_EN
    push(0, 0); push(0, 1); push(0, 2); push(0, 3); push(1, 0); push(1, 1);
`else
    push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(0, 1); push(1, 1);
`endif
    req_in  = 4'b1111;
    ack_out = 1'b1;
    repeat (2) cyc();
    ack_out = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_ack_in", 32'(ack_in), 32'd0);
`ifdef ARB_BURST_EN
      check("stall_id_out", 32'(id_out), 32'd0);
      check("stall_d_out", 32'(d_out), 32'h01);
`else
      check("stall_id_out", 32'(id_out), 32'd1);
      check("stall_d_out", 32'(d_out), 32'h10);
`endif
      cyc();
    end
    ack_out = 1'b1;
    repeat (4) cyc();
    drain();
    do_reset();

    // Single requester (channel 2) with a new word every cycle.
    for (int k = 0; k < 5; k++) push(2, k);
    req_in  = 4'b0100;
    ack_out = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("solo_ack_in", 32'(ack_in), 32'b0100);
      cyc();
      check("solo_id_out", 32'(id_out), 32'd2);
      check("solo_d_out", 32'(d_out), 32'({4'd2, 4'(k)}));
    end
    drain();
    do_reset();

`ifdef ARB_BURST_EN
    // Owner (channel 1) drops after 2 beats; channels 0 and 3 request.
    push(1, 0); push(1, 1);
    push(3, 0); push(3, 1); push(3, 2); push(3, 3);
    push(0, 0);
    req_in  = 4'b0010;
    ack_out = 1'b1;
    repeat (2) cyc();
    req_in = 4'b1001;
    @(negedge clk);
    check("handoff_ack_in", 32'(ack_in), 32'b1000);
    cyc();
    check("handoff_id_out", 32'(id_out), 32'd3);
    check("handoff_req_out", 32'(req_out), 32'd1);
    repeat (4) cyc();
    drain();
    do_reset();
`endif

    check("sb_queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one req/ack stream sink, normally the input port of a FIFO, between N requester channels. One channel is granted per cycle. The accepted word is captured in a registered output stage and tagged with its source channel, so the block is never transparent: minimum latency is 1 cycle, and throughput is 1 word/cycle. An optional burst-lock mode lets one channel hold the grant for up to MAXBURST consecutive beats.

## Interface
Parameters:
- dw, 8: data width per channel.
- N, 4: number of requester channels; legal range 2..8.
- MAXBURST, 4: maximum consecutive beats per grant in burst-lock mode; legal range ≥1; ignored without the macro.
- IW, $clog2(N): width of the channel id (localparam).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- d_in  in  N*dw  packed channel data; channel i occupies bits [i*dw +: dw].
- req_in  in  N  per-channel request/valid.
- ack_in  out  N  per-channel accept; at most one bit high (one-hot or zero).
- d_out  out  dw  registered output data.
- id_out  out  IW  source channel of d_out.
- req_out  out  1  output valid.
- ack_out  in  1  sink accept.

## Operation
- Transfer rule: a transfer happens on a rising edge where req and ack are both high, on either side.
- `space = ~req_out | ack_out`. If space=0, all ack_in are 0 and all state holds.
- Round-robin search: find the first i with req_in[i]=1, starting at (last+1) mod N. `last` is the channel of the most recent accepted word. `sel` is the result; if no channel requests, there is no selection.
- `ack_in[sel] = space`. ack_in is combinational from req_in, req_out and ack_out. Every ack_in bit is 0 while rstn=0.
- On an accepted word:
  - d_out ← d_in[sel].
  - id_out ← sel.
  - req_out ← 1.
  - last ← sel.
- Output register:
  - If the sink takes the word (ack_out=1) and no new word is accepted the same edge, req_out ← 0.
  - If the sink takes a word and a new one is accepted on the same edge, req_out stays 1 with the new word.
- States: IDLE and LOCK; LOCK is used only with the macro. Registers: owner[IW-1:0] and cnt (holds 0..MAXBURST).
- IDLE:
  - On a transfer from channel c with MAXBURST>1: go to LOCK, owner←c, cnt←1.
  - Otherwise stay in IDLE.
- LOCK:
  - If req_in[owner]=1, sel=owner (the round-robin search is overridden). On a transfer, cnt←cnt+1. When cnt+1==MAXBURST, go to IDLE.
  - If req_in[owner]=0, sel comes from the round-robin search starting at owner+1, in the same cycle with no bubble.
    - A transfer from c: owner←c, cnt←1, stay in LOCK.
    - No transfer: go to IDLE.
- Reset values: req_out=0, d_out=0, id_out=0, ack_in=0, last=N-1 (channel 0 has first priority), state IDLE, owner=0, cnt=0.
- Reset mid-operation: the word in the output register is discarded. The first grant after reset release follows the reset priority.

## Timing
- Word accepted on edge k appears on d_out/id_out with req_out=1 from edge k until it is consumed.
- d_out and id_out are stable while req_out=1 and ack_out=0.
- Back-to-back accepts happen with ack_out held high; there are no idle cycles while any channel requests.
- Wrap-around: the round-robin search after channel N-1 resumes at channel 0.
- A request asserted in the same cycle a stall ends may be acked in that cycle.

## Configuration
- Macro: ARB_BURST_EN.
- Defined: IDLE/LOCK burst-lock as described. The grant is held up to MAXBURST beats while the owner keeps requesting.
- Undefined: the LOCK state and the owner/cnt registers are not synthesized. The search rotates after every transfer, equivalent to MAXBURST=1.

## Test plan
- Reset: assert rstn=0 while req_out=1 and all req_in=1 → req_out=0 and ack_in=0 immediately. After release, the first ack_in is 4'b0001 and the first id_out is 0.
- No macro, N=4, all req_in=1, ack_out=1 → id_out sequence 0,1,2,3,0,1,… with req_out continuously high from the first edge onward.
- ARB_BURST_EN, MAXBURST=4, all requesting → id_out sequence 0,0,0,0,1,1,1,1,2,… For each channel, d_out carries d_in values in order.
- Backpressure: ack_out=0 for 3 cycles with req_out=1 → ack_in=0, d_out/id_out unchanged. When ack_out=1, the held word is consumed and the next word is accepted the same edge, with no loss or duplication.
- ARB_BURST_EN, channel 1 owns and drops req after 2 beats while channels 0 and 3 request → the next beat is from channel 3 with no gap, and cnt restarts at 1.
- Only channel 2 requests, with a new word each cycle → ack_in=4'b0100 every cycle, id_out=2, and every word appears one edge after acceptance.
